// File: rtl/timer_pkg.sv
// timer_pkg: shared address codes, TAC layout and FSM states for the timer unit.
package timer_pkg;
  localparam logic [1:0] ADDR_TIMA = 2'b01;
  localparam logic [1:0] ADDR_TMA  = 2'b10;
  localparam logic [1:0] ADDR_TAC  = 2'b11;
  localparam int TAC_EN = 2;
  localparam int TAC_SEL_W = 2;
  localparam logic [7:0] TAC_RD_MASK = 8'hF8;
  typedef enum logic [1:0] {IDLE, OVF, RELOAD} state_t;
endpackage

// File: rtl/timer_tap_edge.sv
// timer_tap_edge: selects a divider tap, gates it with the enable and flags its falling edges.
module timer_tap_edge
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] tac,
  input  logic       tap_4k,
  input  logic       tap_262k,
  input  logic       tap_65k,
  input  logic       tap_16k,
  output logic       inc
);
  logic tap, sig, prev_sig;
  logic [TAC_SEL_W-1:0] tap_sel;
  assign tap_sel = tac[TAC_SEL_W-1:0];
  always_comb
    tap = tap_sel == 2'b00 ? tap_4k :
          tap_sel == 2'b01 ? tap_262k :
          tap_sel == 2'b10 ? tap_65k : tap_16k;
  assign sig = tac[TAC_EN] & tap;
  // disabling or reselecting while high looks like a falling edge, and counts as one
  assign inc = prev_sig & ~sig;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev_sig <= 1'b0;
    else prev_sig <= sig;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: TIMA/TMA/TAC programmable timer with delayed reload and one-cycle interrupt pulse.
module timer_unit
  import timer_pkg::*;
#(
  parameter logic [7:0] TIMA_RST = 8'h00,
  parameter logic [7:0] TMA_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_oe,
  input  logic       tap_4k,
  input  logic       tap_262k,
  input  logic       tap_65k,
  input  logic       tap_16k,
  output logic       int_timer
);
  state_t state, state_n;
  logic [7:0] tima, tima_n, tma;
  logic [2:0] tac;
  logic [8:0] tima_inc;
  logic inc, tima_wr, tma_wr, tac_wr, irq_n;
  timer_tap_edge u_tap_edge (
    .clk(clk), .reset(reset), .tac(tac),
    .tap_4k(tap_4k), .tap_262k(tap_262k), .tap_65k(tap_65k), .tap_16k(tap_16k),
    .inc(inc)
  );
  assign tima_wr  = sel & wr & (addr == ADDR_TIMA);
  assign tma_wr   = sel & wr & (addr == ADDR_TMA);
  assign tac_wr   = sel & wr & (addr == ADDR_TAC);
  assign tima_inc = {1'b0, tima} + 9'd1;
  assign rdata_oe = sel & rd;
  always_comb
    rdata = !rdata_oe           ? 8'h00 :
            addr == ADDR_TIMA   ? tima :
            addr == ADDR_TMA    ? tma :
            addr == ADDR_TAC    ? (TAC_RD_MASK | {5'b0, tac}) : 8'h00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      tima      <= TIMA_RST;
      tma       <= TMA_RST;
      tac       <= 3'b000;
      int_timer <= 1'b0;
    end else begin
      state     <= state_n;
      tima      <= tima_n;
      tma       <= tma_wr ? wdata : tma;
      tac       <= tac_wr ? wdata[2:0] : tac;
      int_timer <= irq_n;
    end
  // RELOAD lets a TMA write land in TIMA too, and ignores CPU TIMA writes
  always_comb begin
    state_n = state;
    tima_n  = tima;
    case (state)
      IDLE:
        if (tima_wr) tima_n = wdata;
        else if (inc) begin
          tima_n  = tima_inc[7:0];
          state_n = tima_inc[8] ? OVF : IDLE;
        end
      OVF: begin
        tima_n  = (tima_wr | tma_wr) ? wdata : tma;
        state_n = tima_wr ? IDLE : RELOAD;
      end
      RELOAD: begin
        state_n = IDLE;
        if (tma_wr) tima_n = wdata;
        else if (inc) begin
          tima_n  = tima_inc[7:0];
          state_n = tima_inc[8] ? OVF : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb irq_n = (state == OVF) & ~tima_wr;
endmodule
